// File: rtl/inst_fetch.sv
// Instruction fetch front end: one-bubble pipeline with a stall hold buffer and redirect.
// Optional FETCH_MISALIGN_CHECK_EN rejects misaligned redirects and pulses misalign_fault_o.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

// state  | meaning
// BUBBLE | memory output stale, nothing presented
// RUN    | ir_i presented directly as the instruction
// HOLD   | stalled instruction presented from the hold buffer
module inst_fetch #(
  parameter int               WIDTH    = `REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic [WIDTH-1:0] pc_o,
  input  logic [WIDTH-1:0] ir_i,
  output logic             inst_valid_o,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] inst_pc_o,
  output logic [WIDTH-1:0] inst_count_o,
  output logic             misalign_fault_o
);

  localparam logic [1:0] BUBBLE = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [WIDTH-1:0] inst_count_q, inst_count_d;

  logic             accept;
  logic             take_redirect;
  logic [WIDTH-1:0] redirect_tgt;
  logic [WIDTH-1:0] pc_next_seq;

  assign inst_valid_o = (state_q != BUBBLE);
  assign accept       = inst_valid_o && !stall_i;
  assign redirect_tgt = redirect_pc_i & WORD_MASK;
  assign pc_next_seq  = pc_q + PC_STEP;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic redirect_aligned;

  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign take_redirect    = redirect_i && redirect_aligned;
  assign misalign_d       = redirect_i && !redirect_aligned;
  assign misalign_fault_o = misalign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  // Low address bits are dropped by the word mask, so every redirect is taken.
  assign take_redirect    = redirect_i;
  assign misalign_fault_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    inst_count_d = inst_count_q + {{(WIDTH-1){1'b0}}, accept};

    if (take_redirect) begin
      // Redirect wins over stall; the memory output for the new target arrives after one bubble.
      state_d     = BUBBLE;
      pc_d        = redirect_tgt;
      hold_inst_d = '0;
      hold_pc_d   = '0;
    end else begin
      case (state_q)
        BUBBLE: begin
          state_d   = RUN;
          pc_d      = pc_next_seq;
          inst_pc_d = pc_q;
        end
        RUN: begin
          if (stall_i) begin
            state_d     = HOLD;
            hold_inst_d = ir_i;
            hold_pc_d   = inst_pc_q;
          end else begin
            pc_d      = pc_next_seq;
            inst_pc_d = pc_q;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_d   = RUN;
            pc_d      = pc_next_seq;
            inst_pc_d = pc_q;
          end
        end
        default: state_d = BUBBLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BUBBLE;
      pc_q         <= RESET_PC & WORD_MASK;
      inst_pc_q    <= '0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      inst_count_q <= inst_count_d;
    end
  end

  // While held, pc stays put so ir_i re-settles to the next sequential word.
  assign pc_o         = pc_q;
  assign inst_o       = (state_q == HOLD) ? hold_inst_q : ir_i;
  assign inst_pc_o    = (state_q == HOLD) ? hold_pc_q : inst_pc_q;
  assign inst_count_o = inst_count_q;

endmodule
